// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: owns ball position and direction, reacts to collision
// codes from the detector, and sequences serve, movement and miss/re-serve.
module ball_motion_ctrl #(
    parameter logic [9:0]  START_X     = 10'd320,
    parameter logic [9:0]  START_Y     = 10'd272,
    parameter logic [9:0]  STEP        = 10'd2,
    parameter logic [19:0] TICK_DIV    = 20'd416667,
    parameter logic [7:0]  SERVE_TICKS = 8'd60,
    parameter logic [3:0]  RST_HOLD    = 4'd4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       GameEnable,
    input  logic [2:0] ColIn,
    output logic [9:0] ballPosX,
    output logic [9:0] ballPosY,
    output logic       ballPosReset,
    output logic       ScorePulse,
    output logic       MissPulse,
    output logic [1:0] StateOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        MOVE  = 2'd2,
        MISS  = 2'd3
    } StateType;

    StateType   state;
    StateType   nextState;
    logic [19:0] tickCnt;
    logic [7:0]  serveCnt;
    logic [3:0]  holdCnt;
    logic [2:0]  lastCode;
    logic        dirX;
    logic        dirY;
    logic        running;
    logic        tick;
    logic        act;
    logic        missHit;

    // Saturating one-step move; the ball never wraps around the 10-bit range.
    function automatic logic [9:0] stepPos(input logic [9:0] pos, input logic dir);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP};
        if (dir)
            return (sum > 11'd1023) ? 10'd1023 : sum[9:0];
        else
            return (pos < STEP) ? 10'd0 : (pos - STEP);
    endfunction

    assign running = GameEnable && ((state == SERVE) || (state == MOVE));
    assign tick    = running && (tickCnt == TICK_DIV - 20'd1);
    // Detector holds its code for several cycles; only a fresh legal code counts.
    assign act     = GameEnable && (state == MOVE) && (ColIn != 3'd0) &&
                     (ColIn != lastCode) && (ColIn < 3'd6);
    assign missHit = act && (ColIn == 3'd4);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (GameEnable) nextState = SERVE;
            SERVE: if (tick && (serveCnt == SERVE_TICKS - 8'd1)) nextState = MOVE;
            MOVE:  if (missHit) nextState = MISS;
            MISS:  if (holdCnt == RST_HOLD - 4'd1) nextState = SERVE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        StateOut     = state;
        ballPosReset = (state == MISS);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ballPosX   <= START_X;
            ballPosY   <= START_Y;
            dirX       <= 1'b1;
            dirY       <= 1'b1;
            tickCnt    <= '0;
            serveCnt   <= '0;
            holdCnt    <= '0;
            lastCode   <= '0;
            ScorePulse <= 1'b0;
            MissPulse  <= 1'b0;
        end else begin
            ScorePulse <= 1'b0;
            MissPulse  <= 1'b0;
            case (state)
                SERVE: begin
                    if (running) begin
                        tickCnt <= tick ? 20'd0 : tickCnt + 20'd1;
                        if (tick)
                            serveCnt <= (serveCnt == SERVE_TICKS - 8'd1) ? 8'd0 : serveCnt + 8'd1;
                    end
                end
                MOVE: begin
                    if (missHit) begin
                        tickCnt   <= '0;
                        MissPulse <= 1'b1;
                        ballPosX  <= START_X;
                        ballPosY  <= START_Y;
                        dirX      <= 1'b1;
                        dirY      <= 1'b1;
                        lastCode  <= '0;
                        holdCnt   <= '0;
                    end else if (GameEnable) begin
                        tickCnt <= tick ? 20'd0 : tickCnt + 20'd1;
                        if (tick) begin
                            ballPosX <= stepPos(ballPosX, dirX);
                            ballPosY <= stepPos(ballPosY, dirY);
                        end
                        if (ColIn == 3'd0) begin
                            lastCode <= '0;
                        end else if (act) begin
                            lastCode <= ColIn;
                            case (ColIn)
                                3'd1: begin
                                    dirX       <= 1'b0;
                                    ScorePulse <= 1'b1;
                                end
                                3'd2: dirY <= 1'b0;
                                3'd3: dirY <= 1'b1;
                                3'd5: dirX <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                MISS: holdCnt <= holdCnt + 4'd1;
                default: ;
            endcase
        end
    end

endmodule
